main_mem_responder: RTL and testbench

- Multi-cycle main-memory model on the responder side of the cache/memory arbitration protocol.
- Accepts one request at a time from the arbiter:
  - Read: an 8-word cache block fill. Words return pipelined, one per cycle, after a fixed latency.
  - Write: a single-word write-through.
- Sits below the cache memory interface in the MEM stage. It is the sole backing store for both I-cache and D-cache misses.

---
 rtl/main_mem_responder.sv | 106 ++++++++++
 tb/tb_main_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_responder.sv
// main_mem_responder: multi-cycle main memory, pipelined 8-word block fills and single-word writes
// Ports: clk/rst (async active-high); mem_request/mem_wr/mem_address/mem_data_in from the arbiter;
// mem_ready (idle), mem_data_out/mem_data_valid/mem_word_index/mem_block_done for fills, mem_write_ack for writes.
module main_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LATENCY = 4,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_WORDS = 32768
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_request,
  input  logic                           mem_wr,
  input  logic [ADDR_W-1:0]              mem_address,
  input  logic [DATA_W-1:0]              mem_data_in,
  output logic                           mem_ready,
  output logic [DATA_W-1:0]              mem_data_out,
  output logic                           mem_data_valid,
  output logic [$clog2(BLOCK_WORDS)-1:0] mem_word_index,
  output logic                           mem_block_done,
  output logic                           mem_write_ack
);
  localparam int IW = $clog2(BLOCK_WORDS);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int D = LATENCY - 1;
  localparam int CW = $clog2((BLOCK_WORDS > LATENCY ? BLOCK_WORDS : LATENCY) + 1);
  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;
  state_t            state_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-IW-2:0] base_q;
  logic              p_v_q [D];
  logic [IW-1:0]     p_i_q [D];
  logic [AW-1:0]     p_a_q [D];
  logic [DATA_W-1:0] mem_q [MEM_WORDS];
  logic              accept, issue, unused;
  logic [IW-1:0]     iss_idx;
  logic [ADDR_W-2:0] iss_word;
  // Word 0 is issued on the acceptance edge itself; the remaining words follow from the counter.
  always_comb begin
    accept = mem_request & mem_ready;
    issue = (accept & ~mem_wr) | (state_q == FILL && cnt_q < CW'(BLOCK_WORDS));
    iss_idx = accept ? '0 : cnt_q[IW-1:0];
    iss_word = {accept ? mem_address[ADDR_W-1:IW+1] : base_q, iss_idx};
  end
  assign unused = mem_address[0];
  always_ff @(posedge clk)
    if (accept && mem_wr && !rst) mem_q[mem_address[AW:1]] <= mem_data_in;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      base_q <= '0;
      for (int i = 0; i < D; i++) begin
        p_v_q[i] <= 1'b0;
        p_i_q[i] <= '0;
        p_a_q[i] <= '0;
      end
      mem_ready <= 1'b1;
      mem_data_out <= '0;
      mem_data_valid <= 1'b0;
      mem_word_index <= '0;
      mem_block_done <= 1'b0;
      mem_write_ack <= 1'b0;
    end else begin
      p_v_q[0] <= issue;
      p_i_q[0] <= iss_idx;
      p_a_q[0] <= iss_word[AW-1:0];
      for (int i = 1; i < D; i++) begin
        p_v_q[i] <= p_v_q[i-1];
        p_i_q[i] <= p_i_q[i-1];
        p_a_q[i] <= p_a_q[i-1];
      end
      mem_data_valid <= p_v_q[D-1];
      mem_word_index <= p_v_q[D-1] ? p_i_q[D-1] : '0;
      mem_block_done <= p_v_q[D-1] && p_i_q[D-1] == IW'(BLOCK_WORDS - 1);
      if (p_v_q[D-1]) mem_data_out <= mem_q[p_a_q[D-1]];
      mem_write_ack <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= mem_wr ? WRITE : FILL;
          cnt_q <= mem_wr ? CW'(LATENCY) : CW'(1);
          base_q <= mem_address[ADDR_W-1:IW+1];
          mem_ready <= 1'b0;
        end
        FILL: begin
          if (cnt_q < CW'(BLOCK_WORDS)) cnt_q <= cnt_q + 1'b1;
          if (mem_block_done) begin
            state_q <= IDLE;
            mem_ready <= 1'b1;
          end
        end
        WRITE: begin
          cnt_q <= cnt_q - 1'b1;
          // Expiring at 2 puts the registered ack in the cycle LATENCY after acceptance.
          if (cnt_q == CW'(2)) begin
            state_q <= IDLE;
            mem_ready <= 1'b1;
            mem_write_ack <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: randomized self-checking bench for three latency variants of main_mem_responder
module tb_main_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [15:0] addr, wdata;
  logic        req [3];
  logic        rdy [3], dv [3], done [3], ack [3];
  logic [15:0] dout [3];
  logic [2:0]  widx [3];
  int          checks = 0, errors = 0;
  logic [15:0] ref_mem [3][32768];
  logic [15:0] last_dout [3];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    main_mem_responder #(.LATENCY(g == 0 ? 4 : (g == 1 ? 2 : 8))) dut (
      .clk(clk), .rst(rst), .mem_request(req[g]), .mem_wr(wr), .mem_address(addr),
      .mem_data_in(wdata), .mem_ready(rdy[g]), .mem_data_out(dout[g]), .mem_data_valid(dv[g]),
      .mem_word_index(widx[g]), .mem_block_done(done[g]), .mem_write_ack(ack[g]));
  end
  function automatic int lat(input int s);
    return s == 0 ? 4 : (s == 1 ? 2 : 8);
  endfunction
  // Entered at a negedge with the responder idle; returns at the negedge where mem_ready is back.
  task automatic do_write(input int s, input logic [15:0] a, input logic [15:0] d);
    int l;
    l = lat(s);
    req[s] = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk); @(negedge clk);
    req[s] = 1'b0; wr = 1'b0;
    ref_mem[s][a[15:1]] = d;
    for (int c = 0; c < l; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (ack[s] !== (c == l - 1)) begin
        errors++;
        $display("FAIL write_ack inst%0d addr %h cyc %0d: got %b want %b", s, a, c, ack[s], c == l - 1);
      end
      checks++;
      if (rdy[s] !== (c == l - 1)) begin
        errors++;
        $display("FAIL write_ready inst%0d addr %h cyc %0d: got %b want %b", s, a, c, rdy[s], c == l - 1);
      end
    end
  endtask
  task automatic do_read(input int s, input logic [15:0] a, input bit hold);
    int l, k;
    bit v;
    logic [15:0] base, exp_d;
    logic [2:0] exp_i;
    l = lat(s);
    base = a & 16'hFFF0;
    req[s] = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk); @(negedge clk);
    req[s] = hold; addr = 16'h0200;
    for (int c = 0; c <= l + 7; c++) begin
      if (c > 0) @(negedge clk);
      if (c == l + 6) req[s] = 1'b0;
      k = c - (l - 1);
      v = k >= 0 && k < 8;
      exp_d = v ? ref_mem[s][int'(base[15:1]) + k] : last_dout[s];
      exp_i = v ? 3'(k) : 3'd0;
      checks++;
      if (dv[s] !== v) begin
        errors++;
        $display("FAIL read_valid inst%0d addr %h cyc %0d: got %b want %b", s, a, c, dv[s], v);
      end
      checks++;
      if (widx[s] !== exp_i) begin
        errors++;
        $display("FAIL read_index inst%0d addr %h cyc %0d: got %0d want %0d", s, a, c, widx[s], exp_i);
      end
      checks++;
      if (done[s] !== (v && k == 7)) begin
        errors++;
        $display("FAIL read_done inst%0d addr %h cyc %0d: got %b want %b", s, a, c, done[s], v && k == 7);
      end
      checks++;
      if (dout[s] !== exp_d) begin
        errors++;
        $display("FAIL read_data inst%0d addr %h cyc %0d: got %h want %h", s, a, c, dout[s], exp_d);
      end
      checks++;
      if (rdy[s] !== (c == l + 7)) begin
        errors++;
        $display("FAIL read_ready inst%0d addr %h cyc %0d: got %b want %b", s, a, c, rdy[s], c == l + 7);
      end
      last_dout[s] = exp_d;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1; wr = 1'b0; addr = '0; wdata = '0;
    req = '{1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      last_dout[s] = '0;
      checks += 6;
      if (rdy[s] !== 1'b1 || dv[s] !== 1'b0 || dout[s] !== 16'h0 || widx[s] !== 3'd0 ||
          done[s] !== 1'b0 || ack[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_values inst%0d: got rdy %b dv %b dout %h idx %0d done %b ack %b want 1 0 0000 0 0 0",
                 s, rdy[s], dv[s], dout[s], widx[s], done[s], ack[s]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask
  task automatic test_preload();
    logic [15:0] blk [4];
    blk = '{16'h0000, 16'h0030, 16'h0100, 16'hFFF0};
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 8; k++)
        do_write(0, blk[b] + 16'(2 * k), 16'((int'(blk[b][15:1]) + k) ^ 16'hA500));
    for (int s = 1; s < 3; s++)
      for (int k = 0; k < 8; k++)
        do_write(s, 16'h0030 + 16'(2 * k), 16'((16'h0018 + k) ^ 16'hA500));
  endtask
  task automatic test_block_read();
    do_read(0, 16'h0034, 1'b0);
  endtask
  task automatic test_read_after_write();
    do_write(0, 16'h0102, 16'h1234);
    do_read(0, 16'h0100, 1'b0);
  endtask
  task automatic test_ignored_request();
    do_read(0, 16'h0030, 1'b1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (dv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL ignored_req cyc %0d: got dv %b rdy %b want 0 1", c, dv[0], rdy[0]);
      end
    end
  endtask
  task automatic test_wrap();
    do_read(0, 16'hFFFE, 1'b0);
  endtask
  task automatic test_reset_mid_fill();
    req[0] = 1'b1; wr = 1'b0; addr = 16'h0034;
    @(posedge clk); @(negedge clk);
    req[0] = 1'b0;
    repeat (lat(0) + 1) @(negedge clk);
    checks++;
    if (dv[0] !== 1'b1 || widx[0] !== 3'd2) begin
      errors++;
      $display("FAIL pre_reset_word2: got dv %b idx %0d want 1 2", dv[0], widx[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dv[0] !== 1'b0 || rdy[0] !== 1'b1 || dout[0] !== 16'h0 || widx[0] !== 3'd0) begin
      errors++;
      $display("FAIL mid_fill_reset: got dv %b rdy %b dout %h idx %0d want 0 1 0000 0", dv[0], rdy[0], dout[0], widx[0]);
    end
    last_dout = '{16'h0, 16'h0, 16'h0};
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++;
      if (dv[0] !== 1'b0 || rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_idle cyc %0d: got dv %b rdy %b want 0 1", c, dv[0], rdy[0]);
      end
    end
    do_read(0, 16'h0030, 1'b0);
  endtask
  task automatic test_latency_sweep();
    for (int s = 1; s < 3; s++) begin
      do_read(s, 16'h0034, 1'b0);
      do_write(s, 16'h0036, 16'($urandom));
      do_read(s, 16'h0030, 1'b0);
    end
  endtask
  task automatic test_random();
    int s;
    logic [15:0] blk;
    for (int n = 0; n < 16; n++) begin
      s = $urandom_range(0, 2);
      blk = 16'($urandom) & 16'hFFF0;
      for (int k = 0; k < 8; k++)
        do_write(s, blk + 16'(2 * k + $urandom_range(0, 1)), 16'($urandom));
      for (int k = 0; k < 2; k++)
        do_write(s, blk + 16'($urandom_range(0, 15)), 16'($urandom));
      do_read(s, blk + 16'($urandom_range(0, 15)), 1'b0);
    end
  endtask
  initial begin
    test_reset();
    test_preload();
    test_block_read();
    test_read_after_write();
    test_ignored_request();
    test_wrap();
    test_reset_mid_fill();
    test_latency_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
